// File: rtl/signed_updown_counter_7seg.sv
// rtl/signed_updown_counter_7seg.sv - saturating signed up/down counter with button conditioning
// and a sequential double-dabble 7-segment display driver.
module signed_updown_counter_7seg #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2,
    parameter int INIT   = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  inc_btn_i,
    input  logic                  dec_btn_i,
    input  logic                  load_i,
    input  logic [WIDTH:0]        load_value_i,
    output logic [WIDTH:0]        value_o,
    output logic                  is_negative_o,
    output logic                  at_max_o,
    output logic                  at_min_o,
    output logic                  busy_o,
    output logic [7*DIGITS-1:0]   seg_digits_o,
    output logic [6:0]            seg_sign_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [WIDTH:0] MAX_V   = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] MIN_V   = {1'b1, {(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0] FLOOR_V = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] ONE_V   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] INIT_V  = INIT[WIDTH:0];

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_e;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic inc_s1_q, inc_s2_q, inc_prev_q;
    logic dec_s1_q, dec_s2_q, dec_prev_q;
    logic inc_pulse, dec_pulse;

    logic [WIDTH:0] value_q, value_d, load_clamped, neg_val;
    logic [WIDTH-1:0] mag_in;

    state_e               state_q, state_d;
    logic                 first_q, first_d;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic                 sign_q, sign_d;
    logic [WIDTH:0]       lat_q, lat_d;
    logic [WIDTH:0]       last_q, last_d;
    logic [BW-1:0]        bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7*DIGITS-1:0]  seg_digits_q, seg_digits_d, seg_next;
    logic [6:0]           seg_sign_q, seg_sign_d;
    logic                 lead;

    // Two-flop synchronisers plus previous-sample flops for rising-edge detection.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            inc_s1_q   <= 1'b0;
            inc_s2_q   <= 1'b0;
            inc_prev_q <= 1'b0;
            dec_s1_q   <= 1'b0;
            dec_s2_q   <= 1'b0;
            dec_prev_q <= 1'b0;
        end else begin
            inc_s1_q   <= inc_btn_i;
            inc_s2_q   <= inc_s1_q;
            inc_prev_q <= inc_s2_q;
            dec_s1_q   <= dec_btn_i;
            dec_s2_q   <= dec_s1_q;
            dec_prev_q <= dec_s2_q;
        end
    end

    assign inc_pulse = inc_s2_q & ~inc_prev_q;
    assign dec_pulse = dec_s2_q & ~dec_prev_q;

    always_comb begin
        load_clamped = (load_value_i == FLOOR_V) ? MIN_V : load_value_i;
        value_d      = value_q;
        if (load_i) begin
            value_d = load_clamped;
        end else if (inc_pulse && !dec_pulse && value_q != MAX_V) begin
            value_d = value_q + ONE_V;
        end else if (dec_pulse && !inc_pulse && value_q != MIN_V) begin
            value_d = value_q - ONE_V;
        end
    end

    // The range is symmetric, so |value| always fits in WIDTH bits.
    assign neg_val = -value_q;
    assign mag_in  = value_q[WIDTH] ? neg_val[WIDTH-1:0] : value_q[WIDTH-1:0];

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking walks from the most significant digit down; units always shows.
    always_comb begin
        seg_next = '1;
        lead     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (lead && i != 0 && bcd_q[4*i +: 4] == 4'd0) begin
                seg_next[7*i +: 7] = 7'h7F;
            end else begin
                lead               = 1'b0;
                seg_next[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        mag_d        = mag_q;
        sign_d       = sign_q;
        lat_d        = lat_q;
        last_d       = last_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        seg_digits_d = seg_digits_q;
        seg_sign_d   = seg_sign_q;
        case (state_q)
            IDLE: begin
                if (first_q || value_q != last_q) begin
                    state_d = SHIFT;
                    first_d = 1'b0;
                    mag_d   = mag_in;
                    sign_d  = value_q[WIDTH];
                    lat_d   = value_q;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                bcd_d = (bcd_adj << 1) | BW'(mag_q[WIDTH-1]);
                mag_d = mag_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                seg_digits_d = seg_next;
                seg_sign_d   = sign_q ? 7'h3F : 7'h7F;
                last_d       = lat_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            value_q      <= INIT_V;
            state_q      <= IDLE;
            first_q      <= 1'b1;
            mag_q        <= '0;
            sign_q       <= 1'b0;
            lat_q        <= INIT_V;
            last_q       <= INIT_V;
            bcd_q        <= '0;
            cnt_q        <= '0;
            seg_digits_q <= '1;
            seg_sign_q   <= 7'h7F;
        end else begin
            value_q      <= value_d;
            state_q      <= state_d;
            first_q      <= first_d;
            mag_q        <= mag_d;
            sign_q       <= sign_d;
            lat_q        <= lat_d;
            last_q       <= last_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            seg_digits_q <= seg_digits_d;
            seg_sign_q   <= seg_sign_d;
        end
    end

    assign value_o       = value_q;
    assign is_negative_o = value_q[WIDTH];
    assign at_max_o      = (value_q == MAX_V);
    assign at_min_o      = (value_q == MIN_V);
    assign busy_o        = (state_q != IDLE);
    assign seg_digits_o  = seg_digits_q;
    assign seg_sign_o    = seg_sign_q;

endmodule

// File: doc/signed_updown_counter_7seg.md
Name: signed_updown_counter_7seg

Overview:
- Clocked successor to the push-button decrement counter.
- Signed up/down counter with synchronised, edge-detected inc/dec buttons, saturating symmetric range, and synchronous load.
- Sequential double-dabble binary-to-BCD converter drives a parametrised number of active-low 7-segment digits plus a sign digit.
- Sits between the board buttons/switches and the HEX displays.

Parameters:
- WIDTH, 6, magnitude bits; range is -(2^WIDTH-1) .. +(2^WIDTH-1).
- DIGITS, 2, decimal display digits; must satisfy 10^DIGITS > 2^WIDTH-1.
- INIT, 1, signed reset value; must lie within the range.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; asynchronous, active-high.
- inc_btn  input  1  raw increment button, asynchronous, active-high.
- dec_btn  input  1  raw decrement button, asynchronous, active-high.
- load  input  1  synchronous load strobe, already in clk domain.
- load_value  input  WIDTH+1  signed two's-complement load value.
- value  output  WIDTH+1  signed two's-complement count.
- is_negative  output  1  value < 0.
- at_max  output  1  value == +(2^WIDTH-1).
- at_min  output  1  value == -(2^WIDTH-1).
- busy  output  1  BCD conversion in progress.
- seg_digits  output  7*DIGITS  active-low segments, bit order gfedcba; digit 0 (units) in bits [6:0].
- seg_sign  output  7  active-low sign digit.

Behaviour:
- Reset state: value=INIT; is_negative, at_max and at_min are decoded from INIT; busy=0; seg_digits all 1 (blank); seg_sign=7'h7F; synchronisers and edge detectors cleared.
- Input conditioning:
  - inc_btn and dec_btn each pass through a 2-FF synchroniser and a rising-edge detector, producing a 1-cycle pulse.
  - A held button gives exactly one step.
  - Latency is 3 clk from button rise to value change.
- Count update priority, per cycle:
  - load: value <= load_value, clamped to the range if out of range (e.g. -2^WIDTH clamps to -(2^WIDTH-1)).
  - inc and dec pulses in the same cycle: no change.
  - inc only: value+1, saturates at +max with no wrap.
  - dec only: value-1, saturates at -max with no wrap.
- Crossing zero is plain signed arithmetic: 0 dec -> -1, -1 inc -> 0. There is no negative zero.
- is_negative, at_max and at_min are combinational from value.
- Conversion FSM:
  - States: IDLE, SHIFT, UPDATE.
  - IDLE -> SHIFT when value differs from last_converted, or on the first cycle after reset. On entry, latch |value| and sign, clear the BCD register, busy=1.
  - SHIFT: WIDTH cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift the magnitude MSB into the BCD register.
  - UPDATE (1 cycle): write the display registers, set last_converted to the latched value, busy=0, return to IDLE.
  - Display latency: WIDTH+2 clk after the value change (8 at default).
- Value changes during SHIFT do not abort the conversion. The display holds the old value until UPDATE. IDLE then sees the mismatch and restarts immediately, so the final display always equals the final value.
- Segment decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex, gfedcba).
- Leading-zero blanking: every digit above units is blanked (7F) while it and all higher digits are 0. Units always shows, including 0.
- seg_sign: 3F (segment g only) when the latched sign is negative, else 7F.
- Reset asserted mid-conversion aborts immediately to the reset state.

Test Plan:
- Reset with INIT=1, then release -> value=1, busy rises within 1 clk, after 8 clk seg_digits={7F,79}, seg_sign=7F.
- Two dec presses, each held 10 clk -> value 1->0->-1 (7'h7F), is_negative=1; display units=79, tens=7F, seg_sign=3F.
- load=1 with load_value=+63, then inc press -> value stays 63, at_max=1; display tens=02 ("6"), units=30 ("3").
- load_value=7'h40 (-64) -> value=-63, at_min=1; a further dec press leaves the value unchanged.
- inc and dec rising in the same clk -> value unchanged, no conversion started.
- Two inc presses 3 clk apart while busy -> display holds the old value, then a second conversion runs; final display equals the final value; reset asserted mid-SHIFT -> blank display, value=INIT.
